// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Holds the FSM state encoding, the opcode map, ALU/branch codes, the packed
// datapath-control bundle and the opcode classifier used by DECODE.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam int OP_RTYPE = 0;
  localparam int OP_BLTZ  = 1;
  localparam int OP_J     = 2;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_BLE   = 6;
  localparam int OP_ADDI  = 8;
  localparam int OP_SLTIU = 9;
  localparam int OP_SLTI  = 10;
  localparam int OP_ORI   = 13;
  localparam int OP_LUI   = 15;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_SLTU  = 3'b111;

  localparam logic [1:0] BR_BEQ  = 2'd0;
  localparam logic [1:0] BR_BNE  = 2'd1;
  localparam logic [1:0] BR_BLE  = 2'd2;
  localparam logic [1:0] BR_BLTZ = 2'd3;

  typedef enum logic [2:0] {C_R, C_I, C_MEM, C_BR, C_J, C_ILL} op_class_t;

  // Every datapath control line in one bundle so a state can start from '0.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       branch;
    logic [1:0] br_type;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  function automatic op_class_t classify(input logic [31:0] op);
    case (op)
      OP_RTYPE:                                     return C_R;
      OP_ADDI, OP_SLTIU, OP_SLTI, OP_ORI, OP_LUI:   return C_I;
      OP_LW, OP_SW:                                 return C_MEM;
      OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ:              return C_BR;
      OP_J:                                         return C_J;
      default:                                      return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [31:0] op);
    case (op)
      OP_SLTIU: return ALU_SLTU;
      OP_SLTI:  return ALU_SLT;
      OP_ORI:   return ALU_OR;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] branch_type(input logic [31:0] op);
    case (op)
      OP_BNE:  return BR_BNE;
      OP_BLE:  return BR_BLE;
      OP_BLTZ: return BR_BLTZ;
      default: return BR_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: wraps modulo 2^W, cleared asynchronously.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  // Count one per retire pulse; natural overflow gives the wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + W'(1);
  end

  assign count = cnt_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM sequencing each instruction
// over 3-5 cycles with memory-ready stalls and a retired-instruction counter.
// Build option: define ILLEGAL_TRAP_EN to trap on illegal opcodes (adds
// illegal_o); otherwise illegal opcodes retire as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int RET_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               IRWrite_o,
  output logic               IorD_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic               RegDst_o,
  output logic               Branch_o,
  output logic [1:0]         BranchType_o,
  output logic               Jump_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [1:0]         MemtoReg_o,
  output logic               instr_done_o,
  output logic [RET_W-1:0]   retired_o,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_o,
`endif
  output logic [3:0]         state_o
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  ctrl_t           c, o;
  logic            done;
`ifdef ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Opcode is captured in DECODE so later states ignore instr_op_i changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    op_q <= '0;
    else if (state_q == S_DECODE) op_q <= instr_op_i;
  end

  // Next-state and Moore control decode; all lines default to 0.
  always_comb begin
    state_d = state_q;
    c       = '0;
    done    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_ready_i;
        c.pc_write  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target: PC + (imm << 2).
        c.alu_src_b = 2'd3;
        c.alu_op    = ALU_ADD;
        case (classify(32'(instr_op_i)))
          C_R:     state_d = S_EXEC_R;
          C_I:     state_d = S_EXEC_I;
          C_MEM:   state_d = S_MEM_ADDR;
          C_BR:    state_d = S_BRANCH;
          C_J:     state_d = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            done    = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd0;
        c.alu_op    = ALU_FUNCT;
        state_d     = S_WB_ALU;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = imm_alu_op(32'(op_q));
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (32'(op_q) == OP_RTYPE);
        done        = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = ALU_ADD;
        state_d     = (32'(op_q) == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'd1;
        done         = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready_i) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd0;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.br_type   = branch_type(32'(op_q));
        done        = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        c.jump     = 1'b1;
        c.pc_write = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // Sticky until reset; no retire.
        illegal = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low, including the combinational FETCH lines.
  assign o = rst_i ? '0 : c;

  assign PCWrite_o    = o.pc_write;
  assign IRWrite_o    = o.ir_write;
  assign IorD_o       = o.iord;
  assign RegWrite_o   = o.reg_write;
  assign ALU_op_o     = ALUOP_W'(o.alu_op);
  assign ALUSrcA_o    = o.alu_src_a;
  assign ALUSrcB_o    = o.alu_src_b;
  assign RegDst_o     = o.reg_dst;
  assign Branch_o     = o.branch;
  assign BranchType_o = o.br_type;
  assign Jump_o       = o.jump;
  assign MemRead_o    = o.mem_read;
  assign MemWrite_o   = o.mem_write;
  assign MemtoReg_o   = o.mem_to_reg;
  assign instr_done_o = done & ~rst_i;
  assign state_o      = rst_i ? 4'd0 : state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o    = illegal & ~rst_i;
`endif

  retire_counter #(.W(RET_W)) u_ret (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (done),
    .count (retired_o)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed tests from the plan plus
// randomized instruction streams with random memory wait states, checked
// against an instruction-level latency/retire model.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  logic        PCWrite_o, IRWrite_o, IorD_o, RegWrite_o;
  logic [2:0]  ALU_op_o;
  logic        ALUSrcA_o;
  logic [1:0]  ALUSrcB_o;
  logic        RegDst_o, Branch_o;
  logic [1:0]  BranchType_o;
  logic        Jump_o, MemRead_o, MemWrite_o;
  logic [1:0]  MemtoReg_o;
  logic        instr_done_o;
  logic [31:0] retired_o;
  logic [3:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_ret = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .IorD_o(IorD_o), .RegWrite_o(RegWrite_o),
    .ALU_op_o(ALU_op_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .RegDst_o(RegDst_o),
    .Branch_o(Branch_o), .BranchType_o(BranchType_o), .Jump_o(Jump_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o), .instr_done_o(instr_done_o),
    .retired_o(retired_o),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .state_o(state_o)
  );

  wire [23:0] all_out = {PCWrite_o, IRWrite_o, IorD_o, RegWrite_o, ALU_op_o, ALUSrcA_o,
                         ALUSrcB_o, RegDst_o, Branch_o, BranchType_o, Jump_o, MemRead_o,
                         MemWrite_o, MemtoReg_o, instr_done_o, state_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: base latency with zero wait states.
  function automatic int base_lat(input int op);
    case (op)
      0, 8, 9, 10, 13, 15: return 4;
      35:                  return 5;
      43:                  return 4;
      4, 5, 6, 1, 2:       return 3;
      default:             return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm_alu(input int op);
    case (op)
      8: return 3'b000; 9: return 3'b111; 10: return 3'b100;
      13: return 3'b110; default: return 3'b101;
    endcase
  endfunction

  function automatic logic [1:0] exp_btype(input int op);
    case (op)
      4: return 2'd0; 5: return 2'd1; 6: return 2'd2; default: return 2'd3;
    endcase
  endfunction

  // Runs one instruction from FETCH with fw fetch stalls and mw memory stalls.
  task automatic run_instr(input int op, input int fw, input int mw);
    int f = fw, m = mw, phase = 0, cycles = 0, dones = 0;
    logic [2:0] prev_alu = '0;
    bit finished = 0;
    bit is_mem = (op == 35 || op == 43);
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge clk_i);
      instr_op_i = (phase <= 1) ? op[5:0] : 6'($urandom);
      if (phase == 0) begin
        mem_ready_i = (f == 0);
        if (f > 0) f--;
      end else if (MemRead_o || MemWrite_o) begin
        mem_ready_i = (m == 0);
        if (m > 0) m--;
      end else mem_ready_i = 1'($urandom);
      #1;
      cycles++;
      if (phase == 0) begin
        check("fetch_ctl", {MemRead_o, IorD_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, IRWrite_o, PCWrite_o},
              {1'b1, 1'b0, 1'b0, 2'd1, 3'b000, mem_ready_i, mem_ready_i});
      end else if (phase == 1) begin
        check("decode_ctl", {ALUSrcA_o, ALUSrcB_o, ALU_op_o, MemRead_o, IRWrite_o},
              {1'b0, 2'd3, 3'b000, 1'b0, 1'b0});
      end
      if (instr_done_o) begin
        dones++;
        finished = 1;
        case (op)
          0, 8, 9, 10, 13, 15: begin
            check("wb_alu", {RegWrite_o, MemtoReg_o, RegDst_o}, {1'b1, 2'd0, op == 0});
            check("exec_alu", prev_alu, (op == 0) ? 3'b010 : exp_imm_alu(op));
          end
          35: check("mem_wb", {RegWrite_o, MemtoReg_o, RegDst_o}, {1'b1, 2'd1, 1'b0});
          43: check("mem_wr", {MemWrite_o, IorD_o, RegWrite_o}, {1'b1, 1'b1, 1'b0});
          4, 5, 6, 1: check("branch", {Branch_o, ALU_op_o, BranchType_o, ALUSrcA_o, RegWrite_o},
                            {1'b1, 3'b001, exp_btype(op), 1'b1, 1'b0});
          2: check("jump", {Jump_o, PCWrite_o, RegWrite_o}, {1'b1, 1'b1, 1'b0});
          default: check("nop", {RegWrite_o, MemWrite_o, Jump_o}, 3'b000);
        endcase
      end
      prev_alu = ALU_op_o;
      if (phase == 0 && IRWrite_o) phase = 1;
      else if (phase == 1) phase = 2;
    end
    check($sformatf("latency_op%0d", op), cycles, base_lat(op) + fw + (is_mem ? mw : 0));
    check("done_pulses", dones, 1);
    model_ret++;
    @(posedge clk_i); #1;
    check("retired", retired_o, model_ret);
  endtask

  initial begin
    int ops[$];
    rst_i = 1'b1; mem_ready_i = 1'b0; instr_op_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("reset_outputs", all_out, 24'd0);
    check("reset_retired", retired_o, 0);
    rst_i = 1'b0; #1;
    check("first_fetch", {MemRead_o, state_o}, {1'b1, 4'd0});

    // addi then R-type, no wait states
    run_instr(8, 0, 0);
    run_instr(0, 0, 0);
    check("retired_two", retired_o, 2);
    // lw with 3 memory wait cycles -> 8 total
    run_instr(35, 0, 3);
    run_instr(43, 1, 2);
    foreach (ops[i]) ops.delete(i);
    for (int b = 0; b < 4; b++) run_instr((b == 3) ? 1 : 4 + b, 0, 0);

    // randomized stream
    ops = '{0, 8, 9, 10, 13, 15, 35, 43, 4, 5, 6, 1, 2};
`ifndef ILLEGAL_TRAP_EN
    ops.push_back(3); ops.push_back(7); ops.push_back(63);
`endif
    for (int k = 0; k < 60; k++)
      run_instr(ops[$urandom_range(ops.size() - 1)], $urandom_range(2), $urandom_range(3));

    // reset during MEM_RD wait
    @(negedge clk_i); instr_op_i = 6'd35; mem_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(negedge clk_i); mem_ready_i = 1'b0; #1;
    check("mem_rd_wait", {MemRead_o, IorD_o}, 2'b11);
    @(negedge clk_i); #1;
    check("mem_rd_wait2", {MemRead_o, IorD_o}, 2'b11);
    rst_i = 1'b1; #1;
    check("midreset_outputs", all_out, 24'd0);
    check("midreset_retired", retired_o, 0);
    @(negedge clk_i); #1;
    check("midreset_hold", all_out, 24'd0);
    rst_i = 1'b0; model_ret = 0; #1;
    check("post_reset_fetch", {MemRead_o, IorD_o, state_o, retired_o}, {1'b1, 1'b0, 4'd0, 32'd0});
    mem_ready_i = 1'b1; instr_op_i = 6'd2;

    // counter wrap on jump retire
    @(negedge clk_i);                       // DECODE
    force dut.u_ret.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk_i);                       // JUMP
    release dut.u_ret.cnt_q;
    #1;
    check("wrap_pre", retired_o, 32'hFFFF_FFFF);
    check("wrap_jump", {Jump_o, PCWrite_o, instr_done_o}, 3'b111);
    @(posedge clk_i); #1;
    check("wrap_zero", retired_o, 0);
    model_ret = 0;

    // illegal opcode 63
`ifdef ILLEGAL_TRAP_EN
    @(negedge clk_i); instr_op_i = 6'd63; mem_ready_i = 1'b1;
    @(negedge clk_i);                       // DECODE
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i); #1;
      check("trap_hold", {illegal_o, instr_done_o, RegWrite_o, MemRead_o, PCWrite_o, retired_o},
            {1'b1, 4'b0000, model_ret});
    end
    rst_i = 1'b1; #1;
    check("trap_reset", illegal_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;
`else
    run_instr(63, 0, 0);
    check("illegal_nop_ret", retired_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit: the next-generation decoder for the MIPS-subset datapath. Instead of one combinational decode per instruction, a Moore FSM sequences each instruction over 3-5 cycles and shares one memory and one ALU.
- Stalls on a memory-ready handshake and counts retired instructions.
- Sits between the instruction register opcode field and the datapath muxes/enables.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, width of ALU_op_o to the ALU control
RET_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
instr_op_i  in  OP_W  opcode from instruction register (valid from DECODE onward)
mem_ready_i  in  1  memory completes current read/write this cycle
PCWrite_o  out  1  PC load enable
IRWrite_o  out  1  instruction register load enable
IorD_o  out  1  memory address select: 0=PC, 1=ALU result register
RegWrite_o  out  1  register file write enable
ALU_op_o  out  ALUOP_W  000 add, 001 sub, 010 R-type funct, 100 slt, 101 lui, 110 or, 111 sltu
ALUSrcA_o  out  1  0=PC, 1=rs
ALUSrcB_o  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
RegDst_o  out  1  1=rd, 0=rt
Branch_o  out  1  conditional PC write on branch condition
BranchType_o  out  2  0 beq, 1 bne, 2 ble, 3 bltz
Jump_o  out  1  PC source = jump target
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
MemtoReg_o  out  2  0=ALU result, 1=memory data
instr_done_o  out  1  one-cycle pulse on an instruction's final cycle
retired_o  out  RET_W  retired-instruction count
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset: asynchronous. While rst_i is high, state=FETCH, retired_o=0 and every output is forced to 0. First FETCH cycle is the cycle after rst_i deasserts. Reset mid-instruction aborts it with no retire.
- Outputs are a Moore decode of the state (plus latched opcode fields). Any signal not listed for a state is 0; no X is driven.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=000. IRWrite and PCWrite equal mem_ready_i. Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALU_op=000 (branch target). Next state:
  - opcode 0 -> EXEC_R
  - 8, 9, 10, 13, 15 -> EXEC_I
  - 35, 43 -> MEM_ADDR
  - 4, 5, 6, 1 -> BRANCH
  - 2 -> JUMP
  - other -> illegal handling (see Optional Feature)
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALU_op=010 -> WB_ALU with RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALU_op per opcode: 8 add, 9 sltu, 10 slt, 13 or, 15 lui -> WB_ALU with RegDst=0.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst as latched; retire; -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALU_op=000 -> MEM_RD (35) or MEM_WR (43).
- MEM_RD: MemRead=1, IorD=1; wait for mem_ready_i, then -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1; retire; -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until mem_ready_i; retire on the ready cycle; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALU_op=001, Branch=1, BranchType per opcode (4->0, 5->1, 6->2, 1->3); retire; -> FETCH.
- JUMP: Jump=1, PCWrite=1; retire; -> FETCH.
- Latency with zero wait states:
  - R / I-ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch / jump: 3 cycles
- Each mem_ready_i=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Retire: instr_done_o=1 for exactly one cycle and retired_o increments by 1, wrapping modulo 2^RET_W (all-ones -> 0).
- instr_op_i is sampled in DECODE and held in an internal register for later states. Changes to instr_op_i after DECODE have no effect.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP drives illegal_o=1 (extra 1-bit output port) and all other outputs 0, does not retire, and stays in TRAP until reset.
- Undefined: an illegal opcode is a NOP. DECODE goes to FETCH, instr_done_o pulses, retired_o increments. Port illegal_o is absent.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants (OP_RTYPE=0, OP_BLTZ=1, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_BLE=6, OP_ADDI=8, OP_SLTIU=9, OP_SLTI=10, OP_ORI=13, OP_LUI=15, OP_LW=35, OP_SW=43)
  - ALU_op and BranchType constants
- One sub-module, retire_counter: RET_W-bit wrapping counter with increment enable and async clear.

Test Plan:
- Reset mid-MEM_RD (rst_i pulse with mem_ready_i=0) -> all outputs 0 during reset; FETCH with MemRead=1 on the first cycle after release; retired_o=0.
- addi (op 8) then R-type (op 0), mem_ready_i tied 1 -> each takes 4 cycles; WB_ALU shows RegWrite=1 with RegDst=0, then RegDst=1; retired_o=2 after 8 cycles.
- lw (op 35) with mem_ready_i low 3 cycles in MEM_RD -> 8 total cycles; MemRead=1, IorD=1 throughout the wait; MEM_WB has MemtoReg=1, RegWrite=1.
- Branches op 4, 5, 6, 1 -> BRANCH state with Branch=1, ALU_op=001 and BranchType 0, 1, 2, 3 respectively; 3 cycles each.
- Preload counter to 2^RET_W-1 (force), then retire a jump (op 2) -> Jump=1, PCWrite=1, instr_done_o pulse, retired_o wraps to 0.
- Opcode 63 -> with ILLEGAL_TRAP_EN: TRAP, illegal_o=1 held for 20 cycles, no retire. Without it: return to FETCH, retired_o increments by 1.
